// File: rtl/mips_io_port.sv
// mips_io_port: memory-mapped OUT/IN/STATUS/CTRL window on the MIPS data bus.
// Define MIPS_IO_DEBOUNCE_EN to insert the cand/cnt debounce stage on the input path.
module mips_io_port #(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0100,
    parameter int          IN_WIDTH        = 8,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    output logic [31:0]         ReadData,
    output logic                Hit,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                IRQ
);

    logic [1:0]          idx;
    logic                wr;
    logic                wr_out;
    logic                wr_stat;
    logic                wr_ctrl;
    logic                chg;
    logic                chg_next;
    logic                ie;
    logic                ie_next;
    logic [IN_WIDTH-1:0] sync1;
    logic [IN_WIDTH-1:0] sync2;
    logic [IN_WIDTH-1:0] stable;
    logic [IN_WIDTH-1:0] stable_next;

    assign idx = Address[3:2];
    assign Hit = (Address[31:4] == BASE_ADDR[31:4])
              && (Address[1:0] == 2'b00);

    assign wr      = Hit && MemWrite;
    assign wr_out  = wr && (idx == 2'd0);
    assign wr_stat = wr && (idx == 2'd2);
    assign wr_ctrl = wr && (idx == 2'd3);

    // Load data: selected register on a window hit with MemRead, else zero.
    always_comb begin
        ReadData = 32'h0;
        if (Hit && MemRead) begin
            unique case (idx)
                2'd0: ReadData = PortOut;
                2'd1: ReadData = 32'(stable);
                2'd2: ReadData = {31'h0, chg};
                2'd3: ReadData = {31'h0, ie};
                default: ReadData = 32'h0;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous board input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
        end
    end

`ifdef MIPS_IO_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0] cand;
    logic [IN_WIDTH-1:0] cand_next;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_next;

    // Any disagreement restarts the count; only a full stable run commits.
    always_comb begin
        stable_next = stable;
        cand_next   = cand;
        cnt_next    = '0;
        if (sync2 != cand) begin
            cand_next = sync2;
        end else if (cand != stable) begin
            if (cnt == CNT_MAX) begin
                stable_next = cand;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // Debounce candidate and run-length counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cand <= '0;
            cnt  <= '0;
        end else begin
            cand <= cand_next;
            cnt  <= cnt_next;
        end
    end
`else
    // Without debounce the synchronized value is taken every edge.
    always_comb begin
        stable_next = sync2;
    end
`endif

    // A new stable value beats a same-edge write-1-to-clear.
    always_comb begin
        chg_next = (stable_next != stable)
                 | (chg & ~(wr_stat & WriteData[0]));
        ie_next  = wr_ctrl ? WriteData[0] : ie;
    end

    // Architectural registers and the registered interrupt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            PortOut <= 32'h0;
            stable  <= '0;
            chg     <= 1'b0;
            ie      <= 1'b0;
            IRQ     <= 1'b0;
        end else begin
            if (wr_out) begin
                PortOut <= WriteData;
            end
            stable <= stable_next;
            chg    <= chg_next;
            ie     <= ie_next;
            IRQ    <= chg_next & ie_next;
        end
    end

endmodule

// File: tb/tb_mips_io_port.sv
// tb_mips_io_port: directed bench with a scoreboard queue of expected values.
// Latency expectations follow whether MIPS_IO_DEBOUNCE_EN is defined.
module tb_mips_io_port;

    localparam logic [31:0] BASE = 32'h1001_0100;
`ifdef MIPS_IO_DEBOUNCE_EN
    localparam int LAT = 3 + 16;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    mips_io_port dut (
        .clk(clk),
        .reset(reset),
        .Address(Address),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .ReadData(ReadData),
        .Hit(Hit),
        .PortIn(PortIn),
        .PortOut(PortOut),
        .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard: got %h want queued value", obs);
            return;
        end
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] off, input string tag,
                      input logic [31:0] exp);
        Address = BASE + off;
        MemRead = 1'b1;
        push(tag, exp);
        #1;
        check(ReadData);
        MemRead = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        Address   = BASE + off;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic chk_hit(input logic [31:0] addr, input logic exp);
        Address = addr;
        push("hit", {31'h0, exp});
        #1;
        check({31'h0, Hit});
    endtask

    task automatic chk_out(input string tag, input logic [31:0] exp);
        push(tag, exp);
        check(PortOut);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        push(tag, {31'h0, exp});
        check({31'h0, IRQ});
    endtask

    initial begin
        reset     = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'hA5;

        // Reset state
        tick();
        tick();
        chk_out("rst_out", 32'h0);
        chk_irq("rst_irq", 1'b0);
        rd(32'h4, "rst_in", 32'h0);
        rd(32'h8, "rst_stat", 32'h0);
        chk_hit(BASE + 32'h0, 1'b1);
        chk_hit(BASE + 32'h4, 1'b1);
        chk_hit(BASE + 32'h8, 1'b1);
        chk_hit(BASE + 32'hC, 1'b1);
        chk_hit(BASE + 32'h2, 1'b0);
        chk_hit(BASE + 32'h10, 1'b0);
        chk_hit(BASE - 32'h4, 1'b0);
        PortIn = 8'h00;
        reset  = 1'b1;
        tick();

        // OUT register
        wr(32'h0, 32'hDEAD_BEEF);
        chk_out("out_wr", 32'hDEAD_BEEF);
        rd(32'h0, "out_rd", 32'hDEAD_BEEF);
        Address = BASE;
        MemRead = 1'b0;
        push("rd_noread", 32'h0);
        #1;
        check(ReadData);
        wr(32'h2, 32'h1234_5678);
        chk_out("out_misal", 32'hDEAD_BEEF);
        rd(32'h0, "out_rd2", 32'hDEAD_BEEF);
        wr(32'h4, 32'h0000_00FF);
        rd(32'h4, "in_ro", 32'h0);

        // Input latency: first sampled at edge 1
        PortIn = 8'h3C;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            rd(32'h4, "in_lat", (k < LAT) ? 32'h0 : 32'h3C);
            rd(32'h8, "stat_lat", (k < LAT) ? 32'h0 : 32'h1);
        end
        wr(32'h8, 32'h1);
        rd(32'h8, "stat_w1c", 32'h0);

        // Short glitch
        PortIn = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        PortIn = 8'h3C;
        for (int k = 0; k < 30; k++) begin
            tick();
`ifdef MIPS_IO_DEBOUNCE_EN
            rd(32'h4, "glitch_in", 32'h3C);
`endif
        end
        rd(32'h4, "glitch_in_end", 32'h3C);
`ifdef MIPS_IO_DEBOUNCE_EN
        rd(32'h8, "glitch_stat", 32'h0);
`else
        rd(32'h8, "glitch_stat", 32'h1);
`endif
        wr(32'h8, 32'h1);
        rd(32'h8, "stat_clr2", 32'h0);

        // Interrupt and write-1-to-clear
        wr(32'hC, 32'h1);
        rd(32'hC, "ctrl_rd", 32'h1);
        chk_irq("irq_idle", 1'b0);
        PortIn = 8'h5A;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk_irq("irq_rise", k == LAT);
        end
        rd(32'h8, "stat_irq", 32'h1);
        wr(32'h8, 32'h1);
        rd(32'h8, "stat_clr3", 32'h0);
        chk_irq("irq_fall", 1'b0);

        // Clear on the same edge as a new stable value
        PortIn = 8'hC3;
        for (int k = 1; k < LAT; k++) begin
            tick();
        end
        wr(32'h8, 32'h1);
        rd(32'h8, "set_wins", 32'h1);
        rd(32'h4, "in_c3", 32'hC3);
        chk_irq("irq_set_wins", 1'b1);
        wr(32'hC, 32'h0);
        chk_irq("irq_ie_off", 1'b0);
        rd(32'h8, "stat_keep", 32'h1);
        wr(32'h8, 32'h1);
        rd(32'h8, "stat_clr4", 32'h0);

        // Reset in the middle of a count
        PortIn = 8'h11;
        for (int k = 1; k < 10; k++) begin
            tick();
        end
        reset = 1'b0;
        tick();
        rd(32'h4, "rst_mid_in", 32'h0);
        rd(32'h8, "rst_mid_stat", 32'h0);
        chk_out("rst_mid_out", 32'h0);
        reset = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            rd(32'h4, "relat_in", (k < LAT) ? 32'h0 : 32'h11);
        end
        rd(32'h8, "relat_stat", 32'h1);
        rd(32'hC, "relat_ie", 32'h0);
        chk_irq("relat_irq", 1'b0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
